// File: rtl/spiker_frame_loader_if.sv
// Stream-in / frame-out handshake bundle for spiker_frame_loader.
// The master side feeds words and consumes frames. The slave side is the loader.
interface spiker_frame_loader_if #(
  parameter int WIDTH    = 32,
  parameter int N_SPIKES = 784,
  parameter int CNT_W    = 16
);
  localparam int N_REG = (N_SPIKES + WIDTH - 1) / WIDTH;
  localparam int IDX_W = $clog2(N_REG + 1);

  logic [WIDTH-1:0]    in_data_i;
  logic                in_valid_i;
  logic                in_ready_o;
  logic [N_SPIKES-1:0] frame_o;
  logic                frame_valid_o;
  logic                frame_ready_i;
  logic [IDX_W-1:0]    word_cnt_o;
  logic                pad_err_o;
  logic [CNT_W-1:0]    frames_done_o;

  modport master (
    output in_data_i, in_valid_i, frame_ready_i,
    input  in_ready_o, frame_o, frame_valid_o, word_cnt_o, pad_err_o, frames_done_o
  );

  modport slave (
    input  in_data_i, in_valid_i, frame_ready_i,
    output in_ready_o, frame_o, frame_valid_o, word_cnt_o, pad_err_o, frames_done_o
  );
endinterface

// File: rtl/spiker_frame_loader.sv
// Packs a stream of WIDTH-bit spike words into one N_SPIKES-wide frame for the reader.
// It also flags non-zero padding in the last word and counts the frames that were consumed.
module spiker_frame_loader #(
  parameter int WIDTH    = 32,
  parameter int N_SPIKES = 784,
  parameter int CNT_W    = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  spiker_frame_loader_if.slave bus
);
  localparam int N_REG      = (N_SPIKES + WIDTH - 1) / WIDTH;
  localparam int DATA_WIDTH = N_REG * WIDTH;
  localparam int IDX_W      = $clog2(N_REG + 1);
  localparam int PAD_W      = DATA_WIDTH - N_SPIKES;
  localparam int LAST_W     = N_SPIKES - (N_REG - 1) * WIDTH;
  localparam logic [WIDTH-1:0] ONES     = '1;
  localparam logic [WIDTH-1:0] PAD_MASK = ~(ONES >> PAD_W);

  typedef enum logic {FILL, PRESENT} state_t;

  state_t              state_q, state_d;
  logic [N_SPIKES-1:0] frame_q;
  logic [IDX_W-1:0]    cnt_q;
  logic                pad_err_q;
  logic [CNT_W-1:0]    frames_q;
  logic                in_ready, accept, consume, last_word;

  assign last_word = (cnt_q == IDX_W'(N_REG - 1));

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    accept   = 1'b0;
    consume  = 1'b0;
    case (state_q)
      FILL: begin
        in_ready = !clear_i && !rst_i;
        accept   = bus.in_valid_i && in_ready;
        if (accept && last_word) state_d = PRESENT;
      end
      PRESENT: begin
        consume = bus.frame_ready_i && !clear_i;
        if (consume) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
    if (clear_i) state_d = FILL;
  end

  // The padding bits of the last word are checked on arrival. They are not kept, because they never reach frame_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= FILL;
      frame_q   <= '0;
      cnt_q     <= '0;
      pad_err_q <= 1'b0;
      frames_q  <= '0;
    end else begin
      state_q <= state_d;
      for (int unsigned i = 0; i < N_REG - 1; i++) begin
        if (accept && cnt_q == IDX_W'(i)) frame_q[i*WIDTH +: WIDTH] <= bus.in_data_i;
      end
      if (accept && last_word) frame_q[N_SPIKES-1 -: LAST_W] <= bus.in_data_i[LAST_W-1:0];
      if (clear_i) begin
        cnt_q     <= '0;
        pad_err_q <= 1'b0;
      end else begin
        if (accept) begin
          cnt_q <= cnt_q + 1'b1;
          if (last_word && |(bus.in_data_i & PAD_MASK)) pad_err_q <= 1'b1;
        end
        if (consume) begin
          cnt_q    <= '0;
          frames_q <= frames_q + 1'b1;
        end
      end
    end
  end

  assign bus.in_ready_o    = in_ready;
  assign bus.frame_o       = frame_q;
  assign bus.frame_valid_o = (state_q == PRESENT);
  assign bus.word_cnt_o    = cnt_q;
  assign bus.pad_err_o     = pad_err_q;
  assign bus.frames_done_o = frames_q;
endmodule
